// File: rtl/cpu_run_ctrl.sv
// Run controller for an rv32i core with separate instruction/data BRAMs:
// streams the program in, releases the core, and watches pc for halt or budget overrun.
module cpu_run_ctrl #(
   parameter int RAM_ADDR_WIDTH = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int HALT_CYCLES    = 4,
   parameter int MAX_CYCLES     = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic                      load_target,
   input  logic [DATA_WIDTH-1:0]     load_data,
   input  logic                      load_last,
   output logic                      cpu_rst,
   output logic                      pc_stall,
   input  logic [DATA_WIDTH-1:0]     pc_in,
   input  logic [RAM_ADDR_WIDTH-1:0] cpu_d_w_addr,
   input  logic [DATA_WIDTH-1:0]     cpu_d_w_dat,
   input  logic                      cpu_d_w_enb,
   input  logic [3:0]                cpu_d_w_byte_enb,
   output logic [RAM_ADDR_WIDTH-1:0] i_w_addr,
   output logic [DATA_WIDTH-1:0]     i_w_dat,
   output logic                      i_w_enb,
   output logic [3:0]                i_w_byte_enb,
   output logic [RAM_ADDR_WIDTH-1:0] d_w_addr,
   output logic [DATA_WIDTH-1:0]     d_w_dat,
   output logic                      d_w_enb,
   output logic [3:0]                d_w_byte_enb,
   output logic                      done,
   output logic                      timeout,
   output logic [15:0]               cycle_count
);

   typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, DONE} state_t;

   localparam int SW = $clog2(HALT_CYCLES) + 1;
   localparam logic [SW-1:0] HALT_LAST = SW'(HALT_CYCLES - 1);
   localparam logic [15:0]   CYCLE_LIMIT = 16'(MAX_CYCLES);

   state_t state_reg, state_next;

   logic                      cpu_rst_reg, pc_stall_reg, load_ready_reg;
   logic                      done_reg, timeout_reg;
   logic [15:0]               cycle_count_reg;
   logic [DATA_WIDTH-1:0]     prev_pc_reg;
   logic [SW-1:0]             same_cnt_reg;
   logic [RAM_ADDR_WIDTH-1:0] i_cnt_reg, d_cnt_reg;
   logic [RAM_ADDR_WIDTH-1:0] i_addr_reg, d_addr_reg;
   logic [DATA_WIDTH-1:0]     i_dat_reg, d_dat_reg;
   logic                      i_enb_reg, d_enb_reg;
   logic [3:0]                i_be_reg, d_be_reg;

   logic          beat, start_load, halt_hit, budget_hit, in_run;
   logic [15:0]   cycle_next;
   logic [SW-1:0] same_next;

   assign beat       = load_valid & load_ready_reg;
   assign start_load = start & ((state_reg == IDLE) | (state_reg == DONE));
   assign in_run     = (state_reg == RUN);
   assign cycle_next = cycle_count_reg + 16'd1;
   assign same_next  = (pc_in == prev_pc_reg) ? same_cnt_reg + 1'b1 : '0;
   assign halt_hit   = (same_next == HALT_LAST);
   assign budget_hit = (cycle_next == CYCLE_LIMIT);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    if (beat && load_last) state_next = RELEASE;
         RELEASE: state_next = RUN;
         RUN:     if (halt_hit || budget_hit) state_next = DONE;
         DONE:    if (start) state_next = LOAD;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         cpu_rst_reg     <= 1'b1;
         pc_stall_reg    <= 1'b1;
         load_ready_reg  <= 1'b0;
         done_reg        <= 1'b0;
         timeout_reg     <= 1'b0;
         cycle_count_reg <= '0;
         prev_pc_reg     <= '0;
         same_cnt_reg    <= '0;
         i_cnt_reg       <= '0;
         d_cnt_reg       <= '0;
         i_addr_reg      <= '0;
         d_addr_reg      <= '0;
         i_dat_reg       <= '0;
         d_dat_reg       <= '0;
         i_enb_reg       <= 1'b0;
         d_enb_reg       <= 1'b0;
         i_be_reg        <= '0;
         d_be_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         cpu_rst_reg    <= (state_next == IDLE) || (state_next == LOAD);
         pc_stall_reg   <= (state_next != RUN);
         load_ready_reg <= (state_reg == LOAD) && (state_next == LOAD);
         prev_pc_reg    <= pc_in;
         i_enb_reg      <= 1'b0;
         i_be_reg       <= '0;
         d_enb_reg      <= 1'b0;
         d_be_reg       <= '0;

         if (start_load) begin
            i_cnt_reg       <= '0;
            d_cnt_reg       <= '0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            cycle_count_reg <= '0;
         end

         // One write per accepted beat; counters wrap naturally at the RAM size.
         if ((state_reg == LOAD) && beat) begin
            if (load_target) begin
               d_addr_reg <= d_cnt_reg;
               d_dat_reg  <= load_data;
               d_enb_reg  <= 1'b1;
               d_be_reg   <= 4'hF;
               d_cnt_reg  <= d_cnt_reg + 1'b1;
            end else begin
               i_addr_reg <= i_cnt_reg;
               i_dat_reg  <= load_data;
               i_enb_reg  <= 1'b1;
               i_be_reg   <= 4'hF;
               i_cnt_reg  <= i_cnt_reg + 1'b1;
            end
         end

         if (in_run) begin
            cycle_count_reg <= cycle_next;
            same_cnt_reg    <= same_next;
            if (halt_hit || budget_hit) done_reg <= 1'b1;
            if (budget_hit) timeout_reg <= 1'b1;
         end else begin
            same_cnt_reg <= '0;
         end
      end
   end

   assign cpu_rst      = cpu_rst_reg;
   assign pc_stall     = pc_stall_reg;
   assign load_ready   = load_ready_reg;
   assign done         = done_reg;
   assign timeout      = timeout_reg;
   assign cycle_count  = cycle_count_reg;

   assign i_w_addr     = i_addr_reg;
   assign i_w_dat      = i_dat_reg;
   assign i_w_enb      = i_enb_reg;
   assign i_w_byte_enb = i_be_reg;

   // The core owns the data port only while running; elsewhere its writes are dropped.
   assign d_w_addr     = in_run ? cpu_d_w_addr     : d_addr_reg;
   assign d_w_dat      = in_run ? cpu_d_w_dat      : d_dat_reg;
   assign d_w_enb      = in_run ? cpu_d_w_enb      : d_enb_reg;
   assign d_w_byte_enb = in_run ? cpu_d_w_byte_enb : d_be_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl: loader scoreboard plus a pc-window halt/budget model.
module tb_cpu_run_ctrl;

   localparam int AW   = 12;
   localparam int DW   = 32;
   localparam int HALT = 4;
   localparam int MAXC = 1000;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, load_valid, load_ready, load_target, load_last;
   logic [DW-1:0] load_data;
   logic          cpu_rst, pc_stall;
   logic [DW-1:0] pc_in;
   logic [AW-1:0] cpu_d_w_addr;
   logic [DW-1:0] cpu_d_w_dat;
   logic          cpu_d_w_enb;
   logic [3:0]    cpu_d_w_byte_enb;
   logic [AW-1:0] i_w_addr, d_w_addr;
   logic [DW-1:0] i_w_dat, d_w_dat;
   logic          i_w_enb, d_w_enb;
   logic [3:0]    i_w_byte_enb, d_w_byte_enb;
   logic          done, timeout;
   logic [15:0]   cycle_count;

   int n_vec = 0;
   int n_err = 0;
   int unsigned cnt_i, cnt_d;
   bit          beat_tgt[$];
   logic [31:0] beat_dat[$];

   always #5 clk = ~clk;

   cpu_run_ctrl #(.RAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HALT_CYCLES(HALT), .MAX_CYCLES(MAXC)) dut (
      .clk(clk), .rst(rst), .start(start),
      .load_valid(load_valid), .load_ready(load_ready), .load_target(load_target),
      .load_data(load_data), .load_last(load_last),
      .cpu_rst(cpu_rst), .pc_stall(pc_stall), .pc_in(pc_in),
      .cpu_d_w_addr(cpu_d_w_addr), .cpu_d_w_dat(cpu_d_w_dat),
      .cpu_d_w_enb(cpu_d_w_enb), .cpu_d_w_byte_enb(cpu_d_w_byte_enb),
      .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb),
      .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
      .done(done), .timeout(timeout), .cycle_count(cycle_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      cnt_i = 0;
      cnt_d = 0;
      chk("start_ready", load_ready, 0);
      chk("start_cpu_rst", cpu_rst, 1);
      chk("start_stall", pc_stall, 1);
      chk("start_done", done, 0);
      chk("start_timeout", timeout, 0);
      chk("start_cycles", cycle_count, 0);
   endtask

   // Streams beat_tgt/beat_dat with random gaps, core-write noise and stray start pulses.
   task automatic do_load();
      int  n = beat_tgt.size();
      int  idx = 0;
      int  guard = 0;
      bit  exp_ready = 1'b0;
      bit  acc;
      while (idx < n) begin
         if (guard > n * 8 + 20) begin
            chk("load_budget", 0, 1);
            break;
         end
         guard++;
         load_valid = ($urandom_range(0, 3) != 0);
         if (load_valid) begin
            load_target = beat_tgt[idx];
            load_data   = beat_dat[idx];
            load_last   = (idx == n - 1);
         end else begin
            load_target = 1'($urandom_range(0, 1));
            load_data   = $urandom;
            load_last   = 1'($urandom_range(0, 1));
         end
         cpu_d_w_enb      = 1'($urandom_range(0, 1));
         cpu_d_w_addr     = AW'($urandom);
         cpu_d_w_dat      = $urandom;
         cpu_d_w_byte_enb = 4'($urandom);
         start = ($urandom_range(0, 5) == 0);
         acc = load_valid && exp_ready;
         step();
         start = 1'b0;
         if (acc) begin
            if (beat_tgt[idx]) begin
               chk("ld_d_enb", d_w_enb, 1);
               chk("ld_d_addr", d_w_addr, cnt_d % (1 << AW));
               chk("ld_d_dat", d_w_dat, beat_dat[idx]);
               chk("ld_d_be", d_w_byte_enb, 4'hF);
               chk("ld_i_idle", i_w_enb, 0);
               cnt_d++;
            end else begin
               chk("ld_i_enb", i_w_enb, 1);
               chk(idx == (1 << AW) ? "wrap_addr" : "ld_i_addr", i_w_addr, cnt_i % (1 << AW));
               chk("ld_i_dat", i_w_dat, beat_dat[idx]);
               chk("ld_i_be", i_w_byte_enb, 4'hF);
               chk("ld_d_idle", d_w_enb, 0);
               cnt_i++;
            end
            idx++;
         end else begin
            chk("ld_gap_i", i_w_enb, 0);
            chk("ld_gap_d", d_w_enb, 0);
         end
         exp_ready = (idx < n);
         chk("ld_ready", load_ready, exp_ready);
         chk("ld_cpu_rst", cpu_rst, exp_ready);
         chk("ld_stall", pc_stall, 1);
      end
      load_valid  = 1'b0;
      load_last   = 1'b0;
      cpu_d_w_enb = 1'b0;
      $display("load: %0d beats (%0d instr, %0d data)", n, cnt_i, cnt_d);
   endtask

   task automatic rand_beats(input int n, input int pct_data);
      beat_tgt.delete();
      beat_dat.delete();
      for (int k = 0; k < n; k++) begin
         beat_tgt.push_back($urandom_range(0, 99) < pct_data);
         beat_dat.push_back($urandom);
      end
   endtask

   // mode 0: halting program, 1: endless 3-instruction loop, 2: random sticky pc.
   task automatic do_run(input int mode);
      int unsigned seq[$];
      int          t_end;
      bit          exp_to, win;
      seq.push_back(0);
      for (int k = 0; k < MAXC; k++) begin
         case (mode)
            0: seq.push_back(k < 3 ? k * 4 : 12);
            1: seq.push_back((k % 3) * 4);
            default: seq.push_back($urandom_range(0, 2) == 0 ? $urandom_range(0, 3) * 4
                                                             : seq[seq.size() - 1]);
         endcase
      end
      // Halt once HALT consecutive pc samples (the release-cycle pc included) agree.
      t_end  = MAXC - 1;
      exp_to = 1'b1;
      for (int t = 0; t < MAXC; t++) begin
         win = (t + 1 >= HALT - 1);
         if (win)
            for (int k = 0; k < HALT; k++)
               if (seq[t + 1 - k] != seq[t + 1]) win = 1'b0;
         if (win) begin
            t_end  = t;
            exp_to = (t + 1 == MAXC);
            break;
         end
      end
      pc_in       = seq[0];
      cpu_d_w_enb = 1'b0;
      step();
      for (int t = 0; t <= t_end; t++) begin
         chk("run_stall", pc_stall, 0);
         chk("run_cpu_rst", cpu_rst, 0);
         chk("run_cycles", cycle_count, t);
         chk("run_done", done, 0);
         chk("run_i_enb", i_w_enb, 0);
         pc_in = seq[t + 1];
         if (mode == 0 && t == 3) begin
            cpu_d_w_addr = AW'(1); cpu_d_w_dat = 32'hB;
            cpu_d_w_enb = 1'b1; cpu_d_w_byte_enb = 4'hF;
         end else begin
            cpu_d_w_addr = AW'($urandom); cpu_d_w_dat = $urandom;
            cpu_d_w_enb = 1'($urandom_range(0, 1)); cpu_d_w_byte_enb = 4'($urandom);
         end
         start = ($urandom_range(0, 7) == 0);
         #1;
         if (mode == 0 && t == 3) begin
            chk("sw_addr", d_w_addr, 1);
            chk("sw_dat", d_w_dat, 32'hB);
            chk("sw_enb", d_w_enb, 1);
         end else begin
            chk("pass_addr", d_w_addr, cpu_d_w_addr);
            chk("pass_dat", d_w_dat, cpu_d_w_dat);
            chk("pass_enb", d_w_enb, cpu_d_w_enb);
            chk("pass_be", d_w_byte_enb, cpu_d_w_byte_enb);
         end
         step();
         start = 1'b0;
      end
      chk("end_done", done, 1);
      chk("end_timeout", timeout, exp_to);
      chk("end_cycles", cycle_count, t_end + 1);
      chk("end_stall", pc_stall, 1);
      chk("end_cpu_rst", cpu_rst, 0);
      cpu_d_w_enb = 1'b1;
      #1;
      chk("done_drop_wr", d_w_enb, 0);
      step();
      cpu_d_w_enb = 1'b0;
      chk("hold_done", done, 1);
      chk("hold_timeout", timeout, exp_to);
      chk("hold_cycles", cycle_count, t_end + 1);
      $display("run: mode %0d ended after %0d cycles, timeout=%0d", mode, t_end + 1, exp_to);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; load_valid = 1'b0; load_target = 1'b0;
      load_data = '0; load_last = 1'b0; pc_in = '0;
      cpu_d_w_addr = '0; cpu_d_w_dat = '0; cpu_d_w_enb = 1'b0; cpu_d_w_byte_enb = '0;
      #12;
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_stall", pc_stall, 1);
      chk("rst_ready", load_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_cycles", cycle_count, 0);
      chk("rst_i_enb", i_w_enb, 0);
      chk("rst_d_enb", d_w_enb, 0);
      @(negedge clk) rst = 1'b1;
      step();

      // Abort a load after three accepted beats with an asynchronous reset.
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         load_valid = 1'b1; load_target = 1'($urandom_range(0, 1));
         load_data = $urandom; load_last = 1'b0;
         step();
      end
      #2 rst = 1'b0;
      #1;
      chk("mid_cpu_rst", cpu_rst, 1);
      chk("mid_stall", pc_stall, 1);
      chk("mid_ready", load_ready, 0);
      chk("mid_i_enb", i_w_enb, 0);
      chk("mid_d_enb", d_w_enb, 0);
      load_valid = 1'b0;
      @(negedge clk) rst = 1'b1;
      step();
      chk("idle_cpu_rst", cpu_rst, 1);
      $display("reset: load aborted after 3 beats");

      // Directed program with interleaved data words.
      beat_tgt = '{0, 1, 0, 0, 1, 0};
      beat_dat = '{32'h00500093, 32'h11111111, 32'h00600113, 32'h002081B3, 32'h22222222, 32'h0000006F};
      pulse_start();
      do_load();
      do_run(0);

      rand_beats(6, 50);
      pulse_start();
      do_load();
      do_run(1);

      for (int r = 0; r < 4; r++) begin
         rand_beats($urandom_range(1, 20), $urandom_range(0, 100));
         pulse_start();
         do_load();
         do_run(2);
      end

      rand_beats((1 << AW) + 1, 0);
      pulse_start();
      do_load();
      do_run(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
